// File: rtl/tictactoe_pkg.sv
// Shared constants and types for the tic-tac-toe move path.
// Error codes are ordered by the priority the decoder applies them in.
package tictactoe_pkg;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_OCC   = 2'd1;
   localparam logic [1:0] ERR_RANGE = 2'd2;
   localparam logic [1:0] ERR_LOCK  = 2'd3;

   localparam logic PLAYER_X = 1'b0;
   localparam logic PLAYER_O = 1'b1;

   typedef enum logic {
      READY = 1'b0,
      CHECK = 1'b1
   } mcd_state_e;

endpackage

// File: rtl/pos_onehot_decoder.sv
// Combinational cell-index to one-hot decoder.
// Indices at or beyond CELLS produce all zeros; they never wrap.
module pos_onehot_decoder #(
   parameter int CELLS = 9,
   parameter int POS_W = 4
) (
   input  logic [POS_W-1:0] i_pos,
   output logic [CELLS-1:0] o_onehot
);

   always_comb begin
      o_onehot = '0;
      for (int i = 0; i < CELLS; i++) begin
         if (i_pos == POS_W'(i)) o_onehot[i] = 1'b1;
      end
   end

endmodule

// File: rtl/move_commit_decoder.sv
// Registered move decoder: accepts a cell index, validates it against the
// board and game state, then commits it to the mover's mask or rejects it.
//
// state | meaning
// READY | move_ready=1, waiting for move_valid; pos is captured on accept
// CHECK | captured move is evaluated; ack or err pulses after the next edge
module move_commit_decoder
   import tictactoe_pkg::*;
#(
   parameter  int CELLS = 9,
   parameter  int POS_W = 4,
   localparam int CNT_W = $clog2(CELLS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             new_game,
   input  logic             game_over,
   input  logic             move_valid,
   input  logic [POS_W-1:0] move_pos,
   output logic             move_ready,
   output logic             move_ack,
   output logic             move_err,
   output logic [1:0]       err_code,
   output logic [CELLS-1:0] cell_en,
   output logic [CELLS-1:0] x_mask,
   output logic [CELLS-1:0] o_mask,
   output logic             turn,
   output logic [CNT_W-1:0] move_count,
   output logic             board_full
);

   if (CELLS < 2 || (2 ** POS_W) < CELLS) begin : g_param_check
      $error("move_commit_decoder: CELLS must be in 2..2**POS_W");
   end

   mcd_state_e       r_state;
   mcd_state_e       w_state_nxt;
   logic [POS_W-1:0] r_pos_q;
   logic [CELLS-1:0] r_x_mask;
   logic [CELLS-1:0] r_o_mask;
   logic             r_turn;
   logic [CNT_W-1:0] r_count;
   logic             r_ack;
   logic             r_err;
   logic [1:0]       r_err_code;
   logic [CELLS-1:0] r_cell_en;

   logic             w_capture;
   logic             w_eval;
   logic [CELLS-1:0] w_onehot;
   logic             w_full;
   logic             w_range;
   logic             w_occupied;
   logic [1:0]       w_err_code;

   pos_onehot_decoder #(
      .CELLS (CELLS),
      .POS_W (POS_W)
   ) u_pos_dec (
      .i_pos    (r_pos_q),
      .o_onehot (w_onehot)
   );

   assign w_full     = (r_count == CNT_W'(CELLS));
   assign w_range    = ({1'b0, r_pos_q} >= (POS_W + 1)'(CELLS));
   assign w_occupied = |(w_onehot & (r_x_mask | r_o_mask));

   // Lock outranks range, which outranks occupancy.
   always_comb begin
      w_err_code = ERR_NONE;
      if (game_over || w_full) w_err_code = ERR_LOCK;
      else if (w_range)        w_err_code = ERR_RANGE;
      else if (w_occupied)     w_err_code = ERR_OCC;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= READY;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_eval      = 1'b0;
      move_ready  = (r_state == READY);
      if (new_game) begin
         w_state_nxt = READY;
      end else begin
         case (r_state)
            READY: begin
               if (move_valid) begin
                  w_state_nxt = CHECK;
                  w_capture   = 1'b1;
               end
            end
            CHECK: begin
               w_state_nxt = READY;
               w_eval      = 1'b1;
            end
            default: w_state_nxt = READY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pos_q    <= '0;
         r_x_mask   <= '0;
         r_o_mask   <= '0;
         r_turn     <= PLAYER_X;
         r_count    <= '0;
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= ERR_NONE;
         r_cell_en  <= '0;
      end else begin
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= ERR_NONE;
         r_cell_en  <= '0;
         if (w_capture) r_pos_q <= move_pos;
         if (new_game) begin
            r_x_mask <= '0;
            r_o_mask <= '0;
            r_turn   <= PLAYER_X;
            r_count  <= '0;
         end else if (w_eval) begin
            if (w_err_code != ERR_NONE) begin
               r_err      <= 1'b1;
               r_err_code <= w_err_code;
            end else begin
               r_ack     <= 1'b1;
               r_cell_en <= w_onehot;
               if (r_turn == PLAYER_X) r_x_mask <= r_x_mask | w_onehot;
               else                    r_o_mask <= r_o_mask | w_onehot;
               r_turn  <= ~r_turn;
               r_count <= r_count + 1'b1;
            end
         end
      end
   end

   assign move_ack   = r_ack;
   assign move_err   = r_err;
   assign err_code   = r_err_code;
   assign cell_en    = r_cell_en;
   assign x_mask     = r_x_mask;
   assign o_mask     = r_o_mask;
   assign turn       = r_turn;
   assign move_count = r_count;
   assign board_full = w_full;

endmodule

// File: tb/tb_move_commit_decoder.sv
// Bench for move_commit_decoder: a 3x3 and a 4x4 instance driven by directed
// and random moves, checked against a per-cell ownership model.
module tb_move_commit_decoder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       ng [2];
   logic       go [2];
   logic       vld[2];
   logic [3:0] pos[2];

   logic       rdy9, ack9, err9, turn9, full9;
   logic [1:0] code9;
   logic [8:0] ce9, x9, o9;
   logic [3:0] cnt9;

   logic        rdy16, ack16, err16, turn16, full16;
   logic [1:0]  code16;
   logic [15:0] ce16, x16, o16;
   logic [4:0]  cnt16;

   move_commit_decoder #(.CELLS(9), .POS_W(4)) u_dut9 (
      .clk(clk), .rst_n(rst_n), .new_game(ng[0]), .game_over(go[0]),
      .move_valid(vld[0]), .move_pos(pos[0]), .move_ready(rdy9),
      .move_ack(ack9), .move_err(err9), .err_code(code9), .cell_en(ce9),
      .x_mask(x9), .o_mask(o9), .turn(turn9), .move_count(cnt9),
      .board_full(full9)
   );

   move_commit_decoder #(.CELLS(16), .POS_W(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .new_game(ng[1]), .game_over(go[1]),
      .move_valid(vld[1]), .move_pos(pos[1]), .move_ready(rdy16),
      .move_ack(ack16), .move_err(err16), .err_code(code16), .cell_en(ce16),
      .x_mask(x16), .o_mask(o16), .turn(turn16), .move_count(cnt16),
      .board_full(full16)
   );

   int n_pass = 0;
   int n_total = 0;

   // Reference model: owner of each cell (-1 empty, 0 X, 1 O), turn, count.
   int own [2][16];
   int m_turn [2];
   int m_cnt [2];
   int cells [2] = '{9, 16};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [15:0] m_mask(input int s, input int player);
      logic [15:0] m = '0;
      for (int i = 0; i < cells[s]; i++) if (own[s][i] == player) m[i] = 1'b1;
      return m;
   endfunction

   function automatic void model_clear(input int s);
      for (int i = 0; i < 16; i++) own[s][i] = -1;
      m_turn[s] = 0;
      m_cnt[s]  = 0;
   endfunction

   function automatic logic [31:0] obs_x(input int s);
      return (s == 0) ? {23'd0, x9} : {16'd0, x16};
   endfunction
   function automatic logic [31:0] obs_o(input int s);
      return (s == 0) ? {23'd0, o9} : {16'd0, o16};
   endfunction
   function automatic logic [31:0] obs_ce(input int s);
      return (s == 0) ? {23'd0, ce9} : {16'd0, ce16};
   endfunction
   function automatic logic [31:0] obs_cnt(input int s);
      return (s == 0) ? {28'd0, cnt9} : {27'd0, cnt16};
   endfunction

   task automatic check_state(input int s, input string tag);
      chk({tag, "_x_mask"}, obs_x(s), {16'd0, m_mask(s, 0)});
      chk({tag, "_o_mask"}, obs_o(s), {16'd0, m_mask(s, 1)});
      chk({tag, "_turn"},   (s == 0) ? turn9 : turn16, m_turn[s][0]);
      chk({tag, "_count"},  obs_cnt(s), m_cnt[s]);
      chk({tag, "_full"},   (s == 0) ? full9 : full16, (m_cnt[s] == cells[s]) ? 1 : 0);
      chk({tag, "_disjoint"}, obs_x(s) & obs_o(s), 0);
   endtask

   task automatic do_move(input int s, input int p, input bit g, input string tag);
      int e;
      logic [15:0] ce_exp;
      if (g || m_cnt[s] == cells[s]) e = 3;
      else if (p >= cells[s])        e = 2;
      else if (own[s][p] != -1)      e = 1;
      else                           e = 0;
      ce_exp = '0;
      if (e == 0) ce_exp[p] = 1'b1;

      @(negedge clk);
      vld[s] = 1'b1; pos[s] = 4'(p); go[s] = g;
      @(posedge clk); #1;
      vld[s] = 1'b0;
      chk({tag, "_ready_check"}, (s == 0) ? rdy9 : rdy16, 0);
      @(posedge clk); #1;
      go[s] = 1'b0;
      if (e == 0) begin
         own[s][p] = m_turn[s];
         m_turn[s] ^= 1;
         m_cnt[s]++;
      end
      chk({tag, "_ack"},  (s == 0) ? ack9 : ack16, (e == 0) ? 1 : 0);
      chk({tag, "_err"},  (s == 0) ? err9 : err16, (e != 0) ? 1 : 0);
      chk({tag, "_code"}, (s == 0) ? code9 : code16, e);
      chk({tag, "_cell_en"}, obs_ce(s), {16'd0, ce_exp});
      chk({tag, "_ready_after"}, (s == 0) ? rdy9 : rdy16, 1);
      check_state(s, tag);
   endtask

   task automatic new_game_pulse(input int s);
      @(negedge clk); ng[s] = 1'b1;
      @(negedge clk); ng[s] = 1'b0;
      model_clear(s);
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         ng[s] = 1'b0; go[s] = 1'b0; vld[s] = 1'b0; pos[s] = '0;
         model_clear(s);
      end
      #12;
      chk("rst_held_x", {23'd0, x9}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", rdy9, 1);
      chk("rst_ack", ack9, 0);
      chk("rst_err", err9, 0);
      chk("rst_code", code9, 0);
      chk("rst_cell_en", {23'd0, ce9}, 0);
      check_state(0, "rst");

      do_move(0, 4, 0, "x4");
      do_move(0, 0, 0, "o0");
      chk("basic_x_const", {23'd0, x9}, 32'h010);
      chk("basic_o_const", {23'd0, o9}, 32'h001);
      chk("basic_turn_const", turn9, 0);
      chk("basic_cnt_const", {28'd0, cnt9}, 2);

      new_game_pulse(0);
      check_state(0, "ng1");
      do_move(0, 4, 0, "occ_x4");
      do_move(0, 4, 0, "occ_o4");
      chk("occ_turn_const", turn9, 1);
      chk("occ_cnt_const", {28'd0, cnt9}, 1);

      do_move(0, 9, 0, "range9");
      do_move(0, 15, 0, "range15");
      do_move(0, 2, 1, "go_lock");

      new_game_pulse(1);
      do_move(1, 15, 0, "c16_15");
      chk("c16_15_const", {16'd0, ce16}, 32'h8000);
      for (int i = 0; i < 15; i++) do_move(1, i, 0, "c16_fill");
      chk("c16_full_const", full16, 1);
      do_move(1, 3, 0, "c16_lock");

      new_game_pulse(0);
      for (int i = 0; i < 9; i++) do_move(0, i, 0, "fill9");
      chk("fill9_full_const", full9, 1);
      do_move(0, 4, 0, "fill9_lock");
      do_move(0, 12, 0, "fill9_lock_range");

      new_game_pulse(0);
      for (int k = 0; k < 60; k++) begin
         if (m_cnt[0] == 9 && $urandom_range(0, 1) == 1) new_game_pulse(0);
         do_move(0, int'($urandom_range(0, 11)), ($urandom_range(0, 7) == 0), "rand");
      end

      new_game_pulse(0);
      do_move(0, 1, 0, "pend_pre");
      @(negedge clk);
      vld[0] = 1'b1; pos[0] = 4'd2;
      @(posedge clk); #1;
      vld[0] = 1'b0;
      @(negedge clk); ng[0] = 1'b1;
      @(posedge clk); #1;
      model_clear(0);
      chk("pend_ack", ack9, 0);
      chk("pend_err", err9, 0);
      chk("pend_ready", rdy9, 1);
      check_state(0, "pend");
      @(negedge clk); ng[0] = 1'b0;
      @(posedge clk); #1;
      chk("pend_quiet_ack", ack9, 0);
      chk("pend_quiet_err", err9, 0);

      do_move(0, 6, 0, "ar_x6");
      do_move(0, 7, 0, "ar_o7");
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      model_clear(0);
      model_clear(1);
      chk("ar_ready", rdy9, 1);
      chk("ar_ack", ack9, 0);
      chk("ar_err", err9, 0);
      chk("ar_code", code9, 0);
      chk("ar_cell_en", {23'd0, ce9}, 0);
      check_state(0, "ar");
      check_state(1, "ar16");
      @(negedge clk); rst_n = 1'b1;
      do_move(0, 8, 0, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/move_commit_decoder.md
Name: move_commit_decoder

Overview:
- Parametrised, registered successor to the board position decoder.
- Accepts a move (cell index) over a valid/ready handshake and decodes it to a one-hot cell enable.
- Checks the move against board occupancy and game state, then commits it to the current player's mask or rejects it with an error code.
- Sits between the move-entry logic (switch/keypad debounce) and the win checker/display, which consume x_mask/o_mask.

Parameters:
- CELLS, 9, number of board cells (9 for 3x3, 16 for 4x4); legal range 2..2**POS_W.
- POS_W, 4, width of move_pos; 2**POS_W >= CELLS is required, checked by an elaboration-time assertion.
- CNT_W, $clog2(CELLS+1), width of move_count (derived; never overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- new_game  in  1  synchronous clear of board and turn; highest priority.
- game_over  in  1  from win checker; when high, all moves are rejected.
- move_valid  in  1  move request.
- move_pos  in  POS_W  requested cell index.
- move_ready  out  1  block can sample a move this cycle.
- move_ack  out  1  one-cycle pulse: move committed.
- move_err  out  1  one-cycle pulse: move rejected.
- err_code  out  2  reason, valid while move_err=1, else 0.
- cell_en  out  CELLS  one-hot of the committed cell, pulsed with move_ack, else 0.
- x_mask  out  CELLS  cells owned by X.
- o_mask  out  CELLS  cells owned by O.
- turn  out  1  player to move: 0 = X, 1 = O.
- move_count  out  CNT_W  number of committed moves.
- board_full  out  1  move_count == CELLS (combinational from the register).

Behaviour:
- Reset (rst_n=0, async): state=READY; x_mask=o_mask=0; turn=0; move_count=0; move_ack=move_err=0; err_code=0; cell_en=0.
- FSM has two states, READY and CHECK.
- READY:
  - move_ready=1.
  - move_valid=1 at a rising edge captures move_pos into pos_q; next state is CHECK.
- CHECK:
  - move_ready=0; move_valid is ignored.
  - Evaluation is registered; at the next edge state returns to READY and exactly one of move_ack/move_err pulses high for that one cycle.
- Latency: valid sampled at edge N; ack/err high during cycle N+1..N+2 (after edge N+1). The block accepts a new move in that same cycle (back-to-back throughput is 1 move per 2 cycles).
- Rejection priority (first match wins):
  - 2'b11 locked: game_over=1 or board_full=1, sampled during CHECK.
  - 2'b10 range: pos_q >= CELLS.
  - 2'b01 occupied: (x_mask|o_mask)[pos_q]=1.
  - On reject: masks, turn and count are unchanged; cell_en=0.
- Commit:
  - onehot(pos_q) is ORed into x_mask if turn=0, else into o_mask.
  - turn toggles; move_count increments; cell_en=onehot(pos_q); err_code=0.
- new_game=1 at an edge:
  - Same clears as reset, except it is synchronous; state goes to READY and any move in CHECK is dropped (no ack/err).
  - Overrides a simultaneous move_valid, which is not captured.
- move_count never exceeds CELLS, because the locked check precedes commit.
- Invariant: x_mask & o_mask == 0 at all times.
- Out-of-range indices (CELLS..2**POS_W-1) decode to all-zero one-hot; they never wrap or alias.

Decomposition:
- Package tictactoe_pkg:
  - Error code constants ERR_NONE=0, ERR_OCC=1, ERR_RANGE=2, ERR_LOCK=3.
  - Player constants PLAYER_X=0, PLAYER_O=1.
  - FSM state typedef {READY, CHECK}.
- Sub-module pos_onehot_decoder (params CELLS, POS_W):
  - Purely combinational; in -> CELLS-bit one-hot; all-zero when in >= CELLS.
  - Instantiated once on pos_q.

Test Plan:
- Reset then X@4, O@0 (CELLS=9):
  - Acks with cell_en=9'h010, then 9'h001.
  - Final state x_mask=9'h010, o_mask=9'h001, turn=0, move_count=2.
- Occupied: after X@4, O requests 4 -> move_err=1, err_code=01; masks unchanged; turn stays 1; count stays 1.
- Range: move_pos=9 (CELLS=9) -> err_code=10; then move_pos=15 with CELLS=16, POS_W=4 -> ack, cell_en=16'h8000 (no missing or aliased bits for indices 0..15).
- Fill all 9 cells, then request any cell -> board_full=1, err_code=11; game_over=1 mid-game also gives err_code=11 with no state change.
- new_game asserted in the CHECK cycle of a pending move -> no ack/err, masks=0, turn=0, count=0, move_ready=1 next cycle.
- rst_n dropped asynchronously mid-cycle with masks non-zero -> all outputs reach reset values immediately, without waiting for a clock edge.
